// File: rtl/edp_muldiv_seq.sv
// EBOX EDP multiply/divide step sequencer: radix-4 Booth multiply, non-restoring divide.
// Define EDP_MULDIV_ABORT_EN to add the abort input that cancels an operation in flight.
module edp_muldiv_seq #(
  parameter int MUL_STEPS = 18,
  parameter int DIV_STEPS = 36,
  parameter int CNT_W     = 6
) (
  input  logic             CLK_EDP,
  input  logic             CLK_EBOX_RESET,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             stall,
`ifdef EDP_MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       mq_lsb,
  input  logic             ad_sign,
  output logic             busy,
  output logic             done,
  output logic             div_ovf,
  output logic [1:0]       ad_func,
  output logic [1:0]       adb_sel,
  output logic             ar_load,
  output logic [1:0]       mq_sel,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] FN_PASS  = 2'b00;
  localparam logic [1:0] FN_ADD   = 2'b01;
  localparam logic [1:0] FN_SUB   = 2'b10;
  localparam logic [1:0] ADB_FM   = 2'b00;
  localparam logic [1:0] ADB_BRX2 = 2'b01;
  localparam logic [1:0] ADB_BR   = 2'b10;
  localparam logic [1:0] MQ_SHL   = 2'b01;
  localparam logic [1:0] MQ_SHR   = 2'b10;
  localparam logic [1:0] MQ_HOLD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_STEPS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_STEP = 3'd1,
    ST_DIV_CHK  = 3'd2,
    ST_DIV_STEP = 3'd3,
    ST_DIV_FIX  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             div_ovf_q;
  logic             booth_prev_q;
  logic             rem_neg_q;
  logic [CNT_W-1:0] step_cnt_q;

  logic             abort_s;
  logic             abort_hit_s;
  logic             freeze_s;
  logic [1:0]       ad_func_s;
  logic [1:0]       adb_sel_s;
  logic [1:0]       mq_sel_s;
  logic             ar_load_s;
  logic             done_s;

  // Booth triplet {mq_lsb[0], mq_lsb[1], booth_prev} -> {AD function, ADB source}.
  function automatic logic [3:0] booth_decode(input logic [2:0] trip);
    logic [3:0] res;
    case (trip)
      3'b001, 3'b010: res = {FN_ADD, ADB_BR};
      3'b011:         res = {FN_ADD, ADB_BRX2};
      3'b100:         res = {FN_SUB, ADB_BRX2};
      3'b101, 3'b110: res = {FN_SUB, ADB_BR};
      default:        res = {FN_PASS, ADB_BR};
    endcase
    return res;
  endfunction

`ifdef EDP_MULDIV_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // busy_q is high exactly in the abortable states, so abort is ignored in IDLE and DONE.
  assign abort_hit_s = abort_s & busy_q;
  assign freeze_s    = stall | abort_hit_s;

  // Per-state control decode; strobes are acted on by the EDP at the next edge.
  always_comb begin
    ad_func_s = FN_PASS;
    adb_sel_s = ADB_BR;
    ar_load_s = 1'b0;
    mq_sel_s  = MQ_HOLD;
    done_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        adb_sel_s = ADB_FM;
      end
      ST_MUL_STEP: begin
        {ad_func_s, adb_sel_s} = booth_decode({mq_lsb[0], mq_lsb[1], booth_prev_q});
        ar_load_s = 1'b1;
        mq_sel_s  = MQ_SHR;
      end
      ST_DIV_CHK: begin
        ad_func_s = FN_SUB;
      end
      ST_DIV_STEP: begin
        ad_func_s = rem_neg_q ? FN_ADD : FN_SUB;
        ar_load_s = 1'b1;
        mq_sel_s  = MQ_SHL;
      end
      ST_DIV_FIX: begin
        if (rem_neg_q) begin
          ad_func_s = FN_ADD;
          ar_load_s = 1'b1;
        end else begin
          ad_func_s = FN_PASS;
          ar_load_s = 1'b0;
        end
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        ad_func_s = FN_PASS;
      end
    endcase
  end

  assign ad_func  = ad_func_s;
  assign adb_sel  = adb_sel_s;
  assign ar_load  = ar_load_s & ~freeze_s;
  assign mq_sel   = freeze_s ? MQ_HOLD : mq_sel_s;
  assign done     = done_s & ~stall;
  assign busy     = busy_q;
  assign div_ovf  = div_ovf_q;
  assign step_cnt = step_cnt_q;

  // Sequencer state machine; stall freezes every register, abort beats stall.
  always_ff @(posedge CLK_EDP) begin
    if (CLK_EBOX_RESET || abort_hit_s) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      div_ovf_q    <= 1'b0;
      booth_prev_q <= 1'b0;
      rem_neg_q    <= 1'b0;
      step_cnt_q   <= CNT_ZERO;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MUL: begin
                state_q      <= ST_MUL_STEP;
                busy_q       <= 1'b1;
                div_ovf_q    <= 1'b0;
                booth_prev_q <= 1'b0;
                step_cnt_q   <= CNT_MUL;
              end
              OP_DIV: begin
                state_q    <= ST_DIV_CHK;
                busy_q     <= 1'b1;
                div_ovf_q  <= 1'b0;
                step_cnt_q <= CNT_DIV;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
        ST_MUL_STEP: begin
          booth_prev_q <= mq_lsb[0];
          step_cnt_q   <= step_cnt_q - CNT_ONE;
          if (step_cnt_q == CNT_ONE) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end
        end
        ST_DIV_CHK: begin
          // A non-negative trial difference means the quotient cannot fit.
          if (!ad_sign) begin
            div_ovf_q <= 1'b1;
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
          end else begin
            rem_neg_q <= 1'b0;
            state_q   <= ST_DIV_STEP;
          end
        end
        ST_DIV_STEP: begin
          rem_neg_q  <= ad_sign;
          step_cnt_q <= step_cnt_q - CNT_ONE;
          if (step_cnt_q == CNT_ONE) begin
            state_q <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed bench for edp_muldiv_seq: Booth triplet table, multiply/divide runs, stall, reset and abort cases.
module tb_edp_muldiv_seq;

  localparam int MUL_STEPS = 18;
  localparam int DIV_STEPS = 36;
  localparam int CNT_W     = 6;

  localparam logic [1:0] OP_MUL   = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] FN_PASS  = 2'b00;
  localparam logic [1:0] FN_ADD   = 2'b01;
  localparam logic [1:0] FN_SUB   = 2'b10;
  localparam logic [1:0] ADB_BRX2 = 2'b01;
  localparam logic [1:0] ADB_BR   = 2'b10;
  localparam logic [1:0] MQ_SHL   = 2'b01;
  localparam logic [1:0] MQ_SHR   = 2'b10;
  localparam logic [1:0] MQ_HOLD  = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             stall;
  logic [1:0]       mq_lsb;
  logic             ad_sign;
  logic             busy;
  logic             done;
  logic             div_ovf;
  logic [1:0]       ad_func;
  logic [1:0]       adb_sel;
  logic             ar_load;
  logic [1:0]       mq_sel;
  logic [CNT_W-1:0] step_cnt;
`ifdef EDP_MULDIV_ABORT_EN
  logic             abort;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] lsb;
    logic [1:0] fn;
    logic [1:0] adb;
  } vec_t;

  vec_t             tab [MUL_STEPS];
  logic [1:0]       lsb_seq [MUL_STEPS];
  logic [1:0]       fn_log [DIV_STEPS];
  logic [1:0]       ab_log [DIV_STEPS];
  logic [CNT_W-1:0] cnt_log [DIV_STEPS];

  always #5 clk = ~clk;

  edp_muldiv_seq #(.MUL_STEPS(MUL_STEPS), .DIV_STEPS(DIV_STEPS), .CNT_W(CNT_W)) dut (
    .CLK_EDP       (clk),
    .CLK_EBOX_RESET(rst),
    .start         (start),
    .op            (op),
    .stall         (stall),
`ifdef EDP_MULDIV_ABORT_EN
    .abort         (abort),
`endif
    .mq_lsb        (mq_lsb),
    .ad_sign       (ad_sign),
    .busy          (busy),
    .done          (done),
    .div_ovf       (div_ovf),
    .ad_func       (ad_func),
    .adb_sel       (adb_sel),
    .ar_load       (ar_load),
    .mq_sel        (mq_sel),
    .step_cnt      (step_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_div_ovf"},  div_ovf,  0);
    chk({tag, "_step_cnt"}, step_cnt, 0);
    chk({tag, "_ad_func"},  ad_func,  0);
    chk({tag, "_adb_sel"},  adb_sel,  0);
    chk({tag, "_ar_load"},  ar_load,  0);
    chk({tag, "_mq_sel"},   mq_sel,   3);
  endtask

  // MQ[34] carries weight 2 and reaches the block as mq_lsb[0]; MQ shifts right arithmetically by 2.
  task automatic fill_from_mq(input logic [35:0] mq0);
    logic signed [35:0] m;
    m = mq0;
    for (int i = 0; i < MUL_STEPS; i++) begin
      lsb_seq[i] = {m[0], m[1]};
      m = m >>> 2;
    end
  endtask

  task automatic mul_run(input int stall_at, input int stall_len, output int dc, output int ld);
    int c;
    int n;
    start = 1'b1; op = OP_MUL;
    tick();
    start = 1'b0; op = 2'b00;
    c = 1; n = 0; dc = -1;
    while (c < 60) begin
      stall  = (c >= stall_at) && (c < stall_at + stall_len);
      mq_lsb = (n < MUL_STEPS) ? lsb_seq[n] : 2'b00;
      #1;
      if (done) begin
        dc = c;
        chk("mul_done_busy", busy, 0);
        break;
      end
      if (stall) begin
        chk("mul_stall_ar_load", ar_load, 0);
        chk("mul_stall_mq_sel", mq_sel, MQ_HOLD);
        chk("mul_stall_cnt", step_cnt, MUL_STEPS + 1 - stall_at);
      end else if (ar_load && n < MUL_STEPS) begin
        fn_log[n] = ad_func;
        ab_log[n] = adb_sel;
        cnt_log[n] = step_cnt;
        chk("mul_step_mq_sel", mq_sel, MQ_SHR);
        n++;
      end else begin
        chk("mul_unexpected_idle_cycle", ar_load, 1);
      end
      tick();
      c++;
    end
    stall = 1'b0;
    ld = n;
    tick();
  endtask

  task automatic div_run(input logic [35:0] pat, output int dc, output int ld,
                         output logic [1:0] fix_fn, output logic fix_ld);
    int c;
    int n;
    start = 1'b1; op = OP_DIV;
    tick();
    start = 1'b0; op = 2'b00;
    c = 1; n = 0; ld = 0; dc = -1; fix_fn = 2'b11; fix_ld = 1'bx;
    while (c < 80) begin
      ad_sign = (c == 1) ? 1'b1 : ((n < DIV_STEPS) ? pat[n] : 1'b0);
      #1;
      if (done) begin
        dc = c;
        break;
      end
      if (c == 1) begin
        chk("div_chk_func", ad_func, FN_SUB);
        chk("div_chk_adb", adb_sel, ADB_BR);
        chk("div_chk_load", ar_load, 0);
        chk("div_chk_mq_sel", mq_sel, MQ_HOLD);
        chk("div_chk_ovf_cleared", div_ovf, 0);
      end else if (mq_sel == MQ_SHL && n < DIV_STEPS) begin
        fn_log[n] = ad_func;
        chk("div_step_load", ar_load, 1);
        n++;
      end else begin
        fix_fn = ad_func;
        fix_ld = ar_load;
      end
      if (ar_load) ld++;
      tick();
      c++;
    end
    ad_sign = 1'b0;
    tick();
  endtask

  initial begin : main
    int dc;
    int ld;
    int c;
    int npulse;
    logic [1:0] fix_fn;
    logic fix_ld;
    logic [35:0] pat;
    logic [1:0] exp_fn;

    // Each row drives one Booth step; together they visit all eight triplets.
    tab[0]  = '{2'b00, FN_PASS, ADB_BR};
    tab[1]  = '{2'b10, FN_ADD,  ADB_BR};
    tab[2]  = '{2'b11, FN_SUB,  ADB_BR};
    tab[3]  = '{2'b00, FN_ADD,  ADB_BR};
    tab[4]  = '{2'b01, FN_SUB,  ADB_BRX2};
    tab[5]  = '{2'b10, FN_ADD,  ADB_BRX2};
    tab[6]  = '{2'b01, FN_SUB,  ADB_BRX2};
    tab[7]  = '{2'b01, FN_SUB,  ADB_BR};
    tab[8]  = '{2'b11, FN_PASS, ADB_BR};
    tab[9]  = '{2'b00, FN_ADD,  ADB_BR};
    for (int i = 10; i < MUL_STEPS; i++) tab[i] = '{2'b00, FN_PASS, ADB_BR};

    rst = 1'b1; start = 1'b0; op = 2'b00; stall = 1'b0; mq_lsb = 2'b00; ad_sign = 1'b0;
`ifdef EDP_MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk_reset("reset");

    start = 1'b1; op = 2'b00;
    tick();
    chk("op00_ignored", busy, 0);
    op = 2'b11;
    tick();
    chk("op11_ignored", busy, 0);
    chk("op11_cnt", step_cnt, 0);
    start = 1'b0; op = 2'b00;

    for (int i = 0; i < MUL_STEPS; i++) lsb_seq[i] = tab[i].lsb;
    mul_run(1000, 0, dc, ld);
    chk("tab_done_cycle", dc, 19);
    chk("tab_loads", ld, 18);
    for (int i = 0; i < MUL_STEPS; i++) begin
      chk($sformatf("tab_fn_%0d", i),  fn_log[i],  tab[i].fn);
      chk($sformatf("tab_adb_%0d", i), ab_log[i],  tab[i].adb);
      chk($sformatf("tab_cnt_%0d", i), cnt_log[i], MUL_STEPS - i);
    end

    fill_from_mq(36'd3);
    mul_run(1000, 0, dc, ld);
    chk("mq3_done_cycle", dc, 19);
    chk("mq3_s1_fn", fn_log[0], FN_SUB);
    chk("mq3_s1_adb", ab_log[0], ADB_BR);
    chk("mq3_s2_fn", fn_log[1], FN_ADD);
    chk("mq3_s2_adb", ab_log[1], ADB_BR);
    chk("mq3_s3_fn", fn_log[2], FN_PASS);
    chk("mq3_s18_fn", fn_log[17], FN_PASS);

    fill_from_mq(36'h800000000);
    mul_run(1000, 0, dc, ld);
    chk("mqneg_done_cycle", dc, 19);
    chk("mqneg_loads", ld, 18);
    chk("mqneg_s17_fn", fn_log[16], FN_PASS);
    chk("mqneg_s18_fn", fn_log[17], FN_SUB);
    chk("mqneg_s18_adb", ab_log[17], ADB_BRX2);

    fill_from_mq(36'd3);
    mul_run(5, 3, dc, ld);
    chk("stall_done_cycle", dc, 22);
    chk("stall_loads", ld, 18);
    chk("stall_s2_fn", fn_log[1], FN_ADD);

    // Remainder sign after step k is pat[k]; step k+1 adds when that sign was negative.
    pat = 36'h80000A5C3;
    div_run(pat, dc, ld, fix_fn, fix_ld);
    chk("div1_done_cycle", dc, 39);
    chk("div1_loads", ld, 37);
    chk("div1_fix_fn", fix_fn, FN_ADD);
    chk("div1_fix_load", fix_ld, 1);
    for (int k = 0; k < DIV_STEPS; k++) begin
      exp_fn = (k == 0) ? FN_SUB : (pat[k-1] ? FN_ADD : FN_SUB);
      chk($sformatf("div1_fn_%0d", k), fn_log[k], exp_fn);
    end

    pat = 36'h012345678;
    div_run(pat, dc, ld, fix_fn, fix_ld);
    chk("div2_done_cycle", dc, 39);
    chk("div2_loads", ld, 36);
    chk("div2_fix_fn", fix_fn, FN_PASS);
    chk("div2_fix_load", fix_ld, 0);
    chk("div2_fn_1", fn_log[1], FN_SUB);
    chk("div2_fn_4", fn_log[4], FN_ADD);

    start = 1'b1; op = OP_DIV;
    tick();
    start = 1'b0; op = 2'b00; ad_sign = 1'b0;
    #1;
    chk("ovf_chk_func", ad_func, FN_SUB);
    chk("ovf_chk_load", ar_load, 0);
    tick();
    chk("ovf_done_c2", done, 1);
    chk("ovf_flag", div_ovf, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_load", ar_load, 0);
    tick();
    chk("ovf_idle_done", done, 0);
    chk("ovf_held", div_ovf, 1);

    start = 1'b1; op = OP_DIV;
    tick();
    start = 1'b0; op = 2'b00; ad_sign = 1'b0;
    tick();
    stall = 1'b1;
    #1;
    chk("done_stall_c2", done, 0);
    tick();
    chk("done_stall_c3", done, 0);
    tick();
    stall = 1'b0;
    #1;
    chk("done_stall_release", done, 1);
    tick();
    chk("done_stall_after", done, 0);
    chk("done_stall_busy", busy, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_clears_ovf");

    mq_lsb = 2'b00;
    start = 1'b1; op = OP_MUL;
    tick();
    c = 1;
    while (c < 10) begin
      start = (c == 5);
      op = (c == 5) ? OP_DIV : 2'b00;
      #1;
      if (c == 6) begin
        chk("busy_start_cnt", step_cnt, 13);
        chk("busy_start_mq_sel", mq_sel, MQ_SHR);
      end
      tick();
      c++;
    end
    start = 1'b0; op = 2'b00;
    #1;
    chk("mid_rst_cnt_step10", step_cnt, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    start = 1'b1; op = OP_MUL;
    tick();
    start = 1'b0; op = 2'b00;
    chk("post_rst_busy", busy, 1);
    chk("post_rst_cnt", step_cnt, 18);
    c = 1; dc = -1;
    while (c < 40) begin
      #1;
      if (done) begin
        dc = c;
        break;
      end
      tick();
      c++;
    end
    chk("post_rst_done_cycle", dc, 19);
    tick();

`ifdef EDP_MULDIV_ABORT_EN
    start = 1'b1; op = OP_MUL;
    tick();
    start = 1'b0; op = 2'b00;
    c = 1;
    while (c < 10) begin
      tick();
      c++;
    end
    abort = 1'b1; stall = 1'b1;
    #1;
    chk("abort_ar_load", ar_load, 0);
    chk("abort_mq_sel", mq_sel, MQ_HOLD);
    tick();
    abort = 1'b0; stall = 1'b0;
    #1;
    chk_reset("abort");
    npulse = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) npulse++;
    end
    chk("abort_no_done", npulse, 0);
`else
    npulse = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edp_muldiv_seq.md
Name: edp_muldiv_seq

Overview:
- Step sequencer for the EBOX EDP adder/MQ datapath during integer multiply and divide.
- Each cycle it issues the AD function, ADB source, AR/ARX load strobes and MQ shift-register function.
- Multiply uses radix-4 Booth recoding from MQ low bits; divide is non-restoring, one quotient bit per step.
- Sits beside CTL; the EDP register updates happen on the same CLK_EDP edge that advances this block.

Parameters:
- MUL_STEPS, 18, Booth steps per multiply (2 multiplier bits per step).
- DIV_STEPS, 36, non-restoring steps per divide.
- CNT_W, 6, step counter width; must satisfy 2**CNT_W > max(MUL_STEPS, DIV_STEPS).

Ports:
- CLK_EDP  input  1  EDP clock.
- CLK_EBOX_RESET  input  1  synchronous active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  01=MUL, 10=DIV; 00 and 11 are ignored.
- stall  input  1  EBUS/cache hold; freezes the sequencer.
- mq_lsb  input  2  EDP.MQ[34:35].
- ad_sign  input  1  EDP.AD[0] of the current-cycle adder result.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_ovf  output  1  divide overflow; held until next start.
- ad_func  output  2  00=PASS(A), 01=ADD, 10=SUB.
- adb_sel  output  2  00=FM, 01=BRx2, 10=BR, 11=ARx4 (matches CRAM ADB encoding).
- ar_load  output  1  load AR/ARX from AD/ADX.
- mq_sel  output  2  00=LOAD, 01=SHL, 10=SHR, 11=HOLD.
- step_cnt  output  CNT_W  steps remaining.

Behaviour:
- Everything is synchronous to CLK_EDP.
- Reset forces IDLE and zeroes busy, done, div_ovf, step_cnt, ad_func, adb_sel, ar_load and the booth_prev bit; mq_sel=HOLD.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, MUL_STEP, DIV_CHK, DIV_STEP, DIV_FIX, DONE.
- Control outputs decode combinationally from the registered state, booth_prev, mq_lsb and ad_sign; they are acted on at the next edge.
- Outside the listed states: ad_func=PASS, adb_sel=BR, ar_load=0, mq_sel=HOLD.
- IDLE:
  - start with op=MUL: step_cnt<=MUL_STEPS, booth_prev<=0, div_ovf<=0, go to MUL_STEP.
  - start with op=DIV: step_cnt<=DIV_STEPS, div_ovf<=0, go to DIV_CHK.
  - Invalid op is ignored.
- MUL_STEP:
  - Triplet t={mq_lsb[0], mq_lsb[1], booth_prev} selects the step:
    - 000/111: PASS.
    - 001/010: ADD BR.
    - 011: ADD BRx2.
    - 100: SUB BRx2.
    - 101/110: SUB BR.
  - Every step: ar_load=1, mq_sel=SHR, booth_prev<=mq_lsb[0], step_cnt decrements.
  - Leaving when step_cnt==1 goes to DONE.
- DIV_CHK:
  - Drives ad_func=SUB, adb_sel=BR, ar_load=0, mq_sel=HOLD.
  - ad_sign==0 means |dividend high| >= divisor: set div_ovf=1 and go to DONE with no steps.
  - Otherwise go to DIV_STEP with rem_neg<=0.
- DIV_STEP:
  - Drives ad_func = rem_neg ? ADD : SUB, adb_sel=BR, ar_load=1, mq_sel=SHL.
  - The datapath shifts the quotient bit in from AD carry.
  - Then rem_neg<=ad_sign and step_cnt decrements; after the last step go to DIV_FIX.
- DIV_FIX:
  - If rem_neg: ADD BR with ar_load=1; otherwise PASS with ar_load=0.
  - mq_sel=HOLD; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; go to IDLE. A start can be accepted on the following cycle.
- busy=1 in every state except IDLE and DONE.
- Stall:
  - While stall=1: state, step_cnt, booth_prev and rem_neg are held; ar_load=0; mq_sel=HOLD.
  - The step repeats once stall drops.
  - Stall in DONE delays the done pulse until stall=0.
- start while busy is ignored. op is sampled only on the accepting cycle.
- Latency:
  - MUL = MUL_STEPS+1 cycles from start to done (no stalls).
  - DIV = DIV_STEPS+3.
  - DIV overflow = 2.

Optional Feature:
- Macro EDP_MULDIV_ABORT_EN.
- When defined: adds input port abort (1 bit).
  - abort=1 in any busy state forces IDLE at the next edge.
  - ar_load=0 and mq_sel=HOLD in that cycle; no done pulse; div_ovf cleared.
  - abort has priority over stall; abort in IDLE or DONE has no effect.
- When undefined: the port does not exist and operations always run to completion.

Test Plan:
- MUL, BR=5, MQ=3 → step 1 t=110 SUB BR, step 2 t=001 ADD BR, remaining steps PASS; done at cycle 19; AR:MQ=15.
- MUL, MQ=0x800000000 (most negative) → final step triplet 100 gives SUB BRx2; 18 ar_load pulses total.
- DIV, AR:ARX=100, BR=7 → DIV_CHK ad_sign=1, 36 steps, DIV_FIX adds if rem_neg; done at cycle 39; MQ=14, AR=2.
- DIV, AR high half=9, BR=7 → div_ovf=1 and done at cycle 2; no ar_load pulses.
- MUL with stall=1 for 3 cycles at step 5 → step_cnt holds at 14, ar_load=0 during stall; done at cycle 22.
- Reset asserted at MUL step 10 → next cycle IDLE with all outputs at reset values; start next cycle accepted normally. With EDP_MULDIV_ABORT_EN, abort at step 10 gives the same result with no done pulse.
